// File: rtl/can_bus_sched.sv
// can_bus_sched
//   Bus-access scheduler between host mailboxes and the single-channel CAN
//   datapath. By default the node listens. The transmitter is granted to one
//   mailbox at a time in round-robin order. Frames that are not acknowledged
//   are retried up to RETRY_MAX attempts. Frames that lose arbitration are
//   re-queued, and the retry count is left unchanged.
//
// Ports
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   req_i               per-mailbox level request
//   sel_o               granted mailbox index
//   done_o / fail_o     one-cycle completion / failure pulse per mailbox
//   retry_cnt_o         no-ack attempts for the held mailbox
//   bus_mode_o          0 idle, 1 receive, 2 transmit
//   tx_start_o          start request to can_tx
//   tx_busy_i, tx_lost_i, tx_acknowledged_i   can_tx status
//   rx_start_o          enable for can_rx
//   rx_busy_i           can_rx frame in progress
//
// Build option
//   CAN_BUS_SCHED_START_WDT_EN  adds a START watchdog. If tx_busy_i does not
//   rise within START_TIMEOUT cycles, the mailbox is failed.
//
// state  | meaning
// IDLE   | bus recessive, decide next activity
// LISTEN | receiver enabled, waiting for traffic or a request
// RX     | receiving a frame
// GRANT  | pick / keep the mailbox to transmit
// START  | start request raised, waiting for can_tx to go busy
// TX     | frame on the bus
module can_bus_sched #(
  parameter int NUM_REQ       = 4,
  parameter int RETRY_MAX     = 8,
  parameter int START_TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [$clog2(NUM_REQ)-1:0] sel_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic [NUM_REQ-1:0]         fail_o,
  output logic [3:0]                 retry_cnt_o,
  output logic [1:0]                 bus_mode_o,
  output logic                       tx_start_o,
  input  logic                       tx_busy_i,
  input  logic                       tx_lost_i,
  input  logic                       tx_acknowledged_i,
  output logic                       rx_start_o,
  input  logic                       rx_busy_i
);

  localparam int SW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LISTEN, ST_RX, ST_GRANT, ST_START, ST_TX
  } state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      sel_q, sel_d, ptr_q, ptr_d, pick_idx, sel_inc;
  logic               hold_q, hold_d, ack_q, ack_d, lost_q, lost_d, pick_vld;
  logic               ack_eff, lost_eff, wdt_expired;
  logic [3:0]         retry_q, retry_d;
  logic [NUM_REQ-1:0] done_d, fail_d;
  logic [1:0]         bus_mode_d;
  logic               tx_start_d, rx_start_d;

`ifdef CAN_BUS_SCHED_START_WDT_EN
  localparam int WW = $clog2(START_TIMEOUT + 1);
  logic [WW-1:0] wdt_q;

  // Reloaded in every state other than START, so START always begins with a full count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   wdt_q <= '0;
    else if (state_q != ST_START) wdt_q <= WW'(START_TIMEOUT - 1);
    else if (wdt_q != '0)        wdt_q <= wdt_q - 1'b1;
  end
  assign wdt_expired = (wdt_q == '0);
`else
  assign wdt_expired = 1'b0;
`endif

  // Search for the first active request at or after the pointer, wrapping around.
  // The loop runs from the highest offset down, so the nearest match is applied last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_i[j]) begin
        pick_vld = 1'b1;
        pick_idx = SW'(j);
      end
    end
  end

  assign sel_inc  = (int'(sel_q) == NUM_REQ - 1) ? '0 : sel_q + 1'b1;
  assign ack_eff  = ack_q | tx_acknowledged_i;
  assign lost_eff = lost_q | tx_lost_i;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    retry_d = retry_q;
    ack_d   = ack_q;
    lost_d  = lost_q;
    done_d  = '0;
    fail_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (rx_busy_i)   state_d = ST_RX;
        else if (|req_i) state_d = ST_GRANT;
        else             state_d = ST_LISTEN;
      end
      ST_LISTEN: begin
        if (rx_busy_i)   state_d = ST_RX;
        else if (|req_i) state_d = ST_GRANT;
      end
      ST_RX: if (!rx_busy_i) state_d = ST_IDLE;
      ST_GRANT: begin
        if (hold_q && req_i[sel_q]) begin
          state_d = ST_START;
        end else if (pick_vld) begin
          sel_d   = pick_idx;
          hold_d  = 1'b1;
          retry_d = '0;
          state_d = ST_START;
        end else begin
          hold_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        ack_d  = 1'b0;
        lost_d = 1'b0;
        if (tx_busy_i)      state_d = ST_TX;
        else if (rx_busy_i) state_d = ST_RX;
        else if (wdt_expired) begin
          fail_d[sel_q] = 1'b1;
          hold_d        = 1'b0;
          ptr_d         = sel_inc;
          state_d       = ST_IDLE;
        end
      end
      ST_TX: begin
        ack_d  = ack_eff;
        lost_d = lost_eff;
        if (!tx_busy_i) begin
          // End of frame: an acknowledgment takes priority over a lost-arbitration flag.
          if (ack_eff) begin
            done_d[sel_q] = 1'b1;
            hold_d        = 1'b0;
            ptr_d         = sel_inc;
            state_d       = ST_IDLE;
          end else if (lost_eff) begin
            state_d = ST_RX;
          end else if (retry_q + 4'd1 == 4'(RETRY_MAX)) begin
            fail_d[sel_q] = 1'b1;
            hold_d        = 1'b0;
            retry_d       = '0;
            ptr_d         = sel_inc;
            state_d       = ST_IDLE;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = ST_IDLE;
          end
        end else if (tx_lost_i) begin
          state_d = ST_RX;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The status outputs are decoded from the next state so that they change on the same edge as the state register.
  always_comb begin
    bus_mode_d = 2'd0;
    tx_start_d = 1'b0;
    rx_start_d = 1'b0;
    case (state_d)
      ST_LISTEN, ST_RX: begin
        bus_mode_d = 2'd1;
        rx_start_d = 1'b1;
      end
      ST_START: begin
        bus_mode_d = 2'd2;
        tx_start_d = 1'b1;
      end
      ST_TX: bus_mode_d = 2'd2;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      hold_q     <= 1'b0;
      retry_q    <= '0;
      ack_q      <= 1'b0;
      lost_q     <= 1'b0;
      done_o     <= '0;
      fail_o     <= '0;
      bus_mode_o <= 2'd0;
      tx_start_o <= 1'b0;
      rx_start_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      retry_q    <= retry_d;
      ack_q      <= ack_d;
      lost_q     <= lost_d;
      done_o     <= done_d;
      fail_o     <= fail_d;
      bus_mode_o <= bus_mode_d;
      tx_start_o <= tx_start_d;
      rx_start_o <= rx_start_d;
    end
  end

  assign sel_o       = sel_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_can_bus_sched.sv
module tb_can_bus_sched;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] req_i = '0;
  logic [1:0] sel_o;
  logic [3:0] done_o, fail_o, retry_cnt_o;
  logic [1:0] bus_mode_o;
  logic       tx_start_o, rx_start_o;
  logic       tx_busy_i = 1'b0, tx_lost_i = 1'b0, tx_acknowledged_i = 1'b0;
  logic       rx_busy_i = 1'b0;

  int checks = 0;
  int failures = 0;

  can_bus_sched #(.NUM_REQ(4), .RETRY_MAX(8), .START_TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .sel_o(sel_o),
    .done_o(done_o), .fail_o(fail_o), .retry_cnt_o(retry_cnt_o),
    .bus_mode_o(bus_mode_o), .tx_start_o(tx_start_o), .tx_busy_i(tx_busy_i),
    .tx_lost_i(tx_lost_i), .tx_acknowledged_i(tx_acknowledged_i),
    .rx_start_o(rx_start_o), .rx_busy_i(rx_busy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (tx_start_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (tx_start_o !== 1'b1) begin
      failures++;
      $display("FAIL %s start_timeout: tx_start_o=%b expected 1", name, tx_start_o);
    end
  endtask

  // Emulates can_tx for one frame that starts in START and ends once busy is sampled low.
  task automatic finish_frame(input logic ack, output logic [3:0] d, output logic [3:0] f,
                              output logic [3:0] rc);
    tx_busy_i = 1'b1;
    step();
    tx_acknowledged_i = ack;
    step();
    tx_acknowledged_i = 1'b0;
    step();
    tx_busy_i = 1'b0;
    step();
    d  = done_o;
    f  = fail_o;
    rc = retry_cnt_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    checks++;
    if ({sel_o, done_o, fail_o, retry_cnt_o, bus_mode_o, tx_start_o, rx_start_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got sel=%0d done=%b fail=%b rc=%0d mode=%0d txs=%b rxs=%b expected all 0",
               sel_o, done_o, fail_o, retry_cnt_o, bus_mode_o, tx_start_o, rx_start_o);
    end
    rst_i = 1'b0;
    step();
    step();
    checks++;
    if (bus_mode_o !== 2'd1 || rx_start_o !== 1'b1) begin
      failures++;
      $display("FAIL listen_mode: mode=%0d rxs=%b expected 1/1", bus_mode_o, rx_start_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] d, f, rc;
    logic [3:0] exp_done [3] = '{4'b0001, 4'b0100, 4'b0001};
    req_i = 4'b0101;
    step();
    checks++;
    if (tx_start_o !== 1'b0) begin
      failures++;
      $display("FAIL rr_start_latency1: tx_start_o=%b expected 0", tx_start_o);
    end
    step();
    checks++;
    if (tx_start_o !== 1'b1) begin
      failures++;
      $display("FAIL rr_start_latency2: tx_start_o=%b expected 1", tx_start_o);
    end
    for (int k = 0; k < 3; k++) begin
      wait_start("rr");
      finish_frame(1'b1, d, f, rc);
      if (k == 2) req_i = 4'b0000;
      checks++;
      if (d !== exp_done[k] || f !== 4'b0000) begin
        failures++;
        $display("FAIL rr_done%0d: done=%b fail=%b expected done=%b fail=0000", k, d, f, exp_done[k]);
      end
    end
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] d, f, rc;
    req_i = 4'b0001;
    wait_start("b2b");
    finish_frame(1'b1, d, f, rc);
    checks++;
    if (d !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_done: done=%b expected 0001", d);
    end
    step();
    checks++;
    if (tx_start_o !== 1'b0 || done_o !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_gap: tx_start_o=%b done=%b expected 0/0000", tx_start_o, done_o);
    end
    step();
    checks++;
    if (tx_start_o !== 1'b1 || sel_o !== 2'd0) begin
      failures++;
      $display("FAIL b2b_restart: tx_start_o=%b sel=%0d expected 1/0", tx_start_o, sel_o);
    end
    req_i = 4'b0000;
    finish_frame(1'b1, d, f, rc);
    checks++;
    if (d !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_dropped_req_done: done=%b expected 0001", d);
    end
    step();
    step();
  endtask

  task automatic test_retry();
    logic [3:0] d, f, rc;
    int bad = 0;
    req_i = 4'b0010;
    for (int n = 1; n <= 8; n++) begin
      wait_start("retry");
      if (sel_o !== 2'd1) bad++;
      finish_frame(1'b0, d, f, rc);
      if (n < 8) begin
        if (d !== 4'b0000 || f !== 4'b0000 || rc !== 4'(n)) bad++;
      end else begin
        req_i = 4'b0000;
        checks++;
        if (f !== 4'b0010 || d !== 4'b0000 || rc !== 4'd0) begin
          failures++;
          $display("FAIL retry_exhausted: fail=%b done=%b rc=%0d expected 0010/0000/0", f, d, rc);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL retry_count: %0d bad attempts expected 0", bad);
    end
    step();
    step();
  endtask

  task automatic test_lost();
    logic [3:0] d, f, rc;
    req_i = 4'b1000;
    wait_start("lost");
    finish_frame(1'b0, d, f, rc);
    wait_start("lost");
    tx_busy_i = 1'b1;
    step();
    tx_lost_i = 1'b1;
    rx_busy_i = 1'b1;
    step();
    checks++;
    if (bus_mode_o !== 2'd1 || tx_start_o !== 1'b0) begin
      failures++;
      $display("FAIL lost_to_rx: mode=%0d txs=%b expected 1/0", bus_mode_o, tx_start_o);
    end
    tx_lost_i = 1'b0;
    tx_busy_i = 1'b0;
    step();
    step();
    rx_busy_i = 1'b0;
    step();
    wait_start("lost");
    checks++;
    if (sel_o !== 2'd3 || retry_cnt_o !== 4'd1) begin
      failures++;
      $display("FAIL lost_regrant: sel=%0d rc=%0d expected 3/1", sel_o, retry_cnt_o);
    end
    finish_frame(1'b1, d, f, rc);
    req_i = 4'b0000;
    checks++;
    if (d !== 4'b1000) begin
      failures++;
      $display("FAIL lost_done: done=%b expected 1000", d);
    end
    step();
    step();
  endtask

  task automatic test_rx_priority();
    logic [3:0] d, f, rc;
    int bad = 0;
    rx_busy_i = 1'b1;
    req_i = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus_mode_o !== 2'd1 || rx_start_o !== 1'b1 || tx_start_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rx_hold: %0d bad cycles expected 0", bad);
    end
    rx_busy_i = 1'b0;
    step();
    checks++;
    if (bus_mode_o !== 2'd0) begin
      failures++;
      $display("FAIL rx_to_idle: mode=%0d expected 0", bus_mode_o);
    end
    wait_start("rx");
    finish_frame(1'b1, d, f, rc);
    req_i = 4'b0000;
    checks++;
    if (d !== 4'b0001) begin
      failures++;
      $display("FAIL rx_then_tx_done: done=%b expected 0001", d);
    end
    step();
    step();
  endtask

  task automatic test_start_wdt();
    int early = 0;
    req_i = 4'b0100;
    wait_start("wdt");
`ifdef CAN_BUS_SCHED_START_WDT_EN
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k < 64 && fail_o !== 4'b0000) early++;
    end
    req_i = 4'b0000;
    checks++;
    if (fail_o !== 4'b0100 || early != 0) begin
      failures++;
      $display("FAIL wdt_fire: fail=%b early=%0d expected 0100/0", fail_o, early);
    end
`else
    begin
      logic [3:0] d, f, rc;
      for (int k = 0; k < 1000; k++) begin
        step();
        if (fail_o !== 4'b0000 || tx_start_o !== 1'b1) early++;
      end
      checks++;
      if (early != 0) begin
        failures++;
        $display("FAIL no_wdt: %0d bad cycles expected 0", early);
      end
      finish_frame(1'b1, d, f, rc);
      req_i = 4'b0000;
    end
`endif
    step();
    step();
  endtask

  task automatic test_reset_mid();
    req_i = 4'b0001;
    wait_start("rst");
    tx_busy_i = 1'b1;
    step();
    checks++;
    if (bus_mode_o !== 2'd2) begin
      failures++;
      $display("FAIL rst_tx_mode: mode=%0d expected 2", bus_mode_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({sel_o, done_o, fail_o, retry_cnt_o, bus_mode_o, tx_start_o, rx_start_o} !== '0) begin
      failures++;
      $display("FAIL rst_async: mode=%0d sel=%0d txs=%b rxs=%b expected all 0",
               bus_mode_o, sel_o, tx_start_o, rx_start_o);
    end
    tx_busy_i = 1'b0;
    req_i = 4'b1001;
    step();
    rst_i = 1'b0;
    step();
    checks++;
    if (tx_start_o !== 1'b0 || bus_mode_o !== 2'd0) begin
      failures++;
      $display("FAIL rst_grant: txs=%b mode=%0d expected 0/0", tx_start_o, bus_mode_o);
    end
    step();
    checks++;
    if (tx_start_o !== 1'b1 || sel_o !== 2'd0) begin
      failures++;
      $display("FAIL rst_pointer: txs=%b sel=%0d expected 1/0", tx_start_o, sel_o);
    end
    req_i = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_retry();
    test_lost();
    test_rx_priority();
    test_start_wdt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
